// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of a 16x8 FIFO memory write port
// among NUM_REQ producers. Owns write/read pointers and occupancy, and drives
// the memory's write and read-address inputs.
module fifo_wr_arbiter #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_REQ   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           pop,
  output logic                           pop_ack,
  output logic                           mem_wr_en,
  output logic [ADDR_SIZE-1:0]           mem_wr_addr,
  output logic [DATA_SIZE-1:0]           mem_wr_data,
  output logic                           mem_full,
  output logic [ADDR_SIZE-1:0]           mem_rd_addr,
  output logic                           full,
  output logic                           empty,
  output logic [ADDR_SIZE:0]             count,
  output logic [2:0]                     grant_id
);

  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [2:0]         LAST_REQ = 3'(NUM_REQ-1);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   cnt;
  logic [2:0]           last_grant;

  logic       hi_found;
  logic       lo_found;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;
  logic [2:0] gnt_idx;
  logic       push;

  assign full        = (cnt == FULL_CNT);
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign mem_full    = full;
  assign mem_wr_addr = wr_ptr;
  assign mem_rd_addr = rd_ptr;
  assign pop_ack     = pop & ~empty & ~rst;

  // Round-robin search: the lowest valid index above last_grant wins,
  // otherwise wrap around to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
        if (3'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
  end

  assign gnt_idx   = hi_found ? hi_idx : lo_idx;
  // No grant while full, even if a pop frees a slot this cycle.
  assign push      = (hi_found | lo_found) & ~full & ~rst;
  assign mem_wr_en = push;
  assign grant_id  = gnt_idx;

  // One-hot ready and write-data mux for the granted producer.
  always_comb begin
    req_ready   = '0;
    mem_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        req_ready[i] = push;
        mem_wr_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Pointer, occupancy and priority state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_grant <= LAST_REQ;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + ADDR_SIZE'(1);
        last_grant <= gnt_idx;
      end
      if (pop_ack) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      if (push && !pop_ack) begin
        cnt <= cnt + (ADDR_SIZE+1)'(1);
      end else if (!push && pop_ack) begin
        cnt <= cnt - (ADDR_SIZE+1)'(1);
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Single-clock controller that shares the write port of the 16x8 FIFO memory between NUM_REQ producers using round-robin arbitration.
- Owns the write pointer, read pointer and occupancy, and generates full/empty.
- Drives the memory's wr_en, wr_addr, wr_data, full and rd_addr.
- The memory's asynchronous read data is the pop data in the cycle pop_ack is high.

Parameters:
- ADDR_SIZE, 4, memory address width; DEPTH = 2**ADDR_SIZE.
- DATA_SIZE, 8, data word width.
- DEPTH, 16, entries; must equal 2**ADDR_SIZE.
- NUM_REQ, 4, number of producers (2..8).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  producer i has a word.
- req_data  in  NUM_REQ*DATA_SIZE  producer i word at bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- pop  in  1  consumer read request.
- pop_ack  out  1  pop accepted; memory rd_data is valid this cycle.
- mem_wr_en  out  1  to memory wr_en.
- mem_wr_addr  out  ADDR_SIZE  to memory wr_addr.
- mem_wr_data  out  DATA_SIZE  to memory wr_data.
- mem_full  out  1  to memory full; same as full.
- mem_rd_addr  out  ADDR_SIZE  to memory rd_addr.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_SIZE+1  occupancy 0..DEPTH.
- grant_id  out  3  index of the current grant; valid only when mem_wr_en = 1.

Behaviour:
- Registers: wr_ptr and rd_ptr (ADDR_SIZE bits each), cnt (ADDR_SIZE+1 bits), last_grant (3 bits).
- Reset (rst high at an edge):
  - wr_ptr = 0, rd_ptr = 0, cnt = 0, last_grant = NUM_REQ-1.
  - Resulting outputs: full = 0, empty = 1, count = 0, mem_wr_addr = 0, mem_rd_addr = 0.
  - While rst is high, req_ready, mem_wr_en and pop_ack are forced to 0.
  - Reset mid-operation discards all contents; memory array contents are don't-care after reset.
- Arbitration (combinational from registers and req_valid):
  - Search starts at index last_grant+1 mod NUM_REQ and takes the first i with req_valid[i] = 1.
  - req_ready[i] = 1 only for that i, and only when full = 0.
  - req_ready is never high for a requester whose req_valid is low.
  - At most one req_ready bit is high.
- Push:
  - push = |(req_valid & req_ready).
  - mem_wr_en = push; mem_wr_data = the granted slice; mem_wr_addr = wr_ptr.
  - The memory captures the word on the same edge: zero-cycle latency from handshake to write.
  - On push: wr_ptr += 1 (wraps 15 -> 0), last_grant = granted index.
  - With no push, last_grant holds. Idle cycles do not rotate priority.
- Producer rule: req_valid and data must hold until the handshake. The arbiter does not check this.
- Pop:
  - pop_ack = pop & ~empty; mem_rd_addr = rd_ptr at all times.
  - On pop_ack: rd_ptr += 1 with wrap.
  - Pop while empty is ignored: no state change, pop_ack = 0.
- Occupancy:
  - push only: cnt +1. pop_ack only: cnt -1. Both or neither: cnt unchanged.
- Boundaries:
  - When full, no grant is given, even if pop_ack is high the same cycle; the freed slot is usable next cycle.
  - When empty, a same-cycle push and pop gives pop_ack = 0 (no bypass); the word is readable next cycle.
  - Pointer wrap is modulo DEPTH; full vs empty is decided only by cnt.
  - mem_full = full guarantees the memory-side gating never drops a granted push.
- Fairness: with all NUM_REQ requesters continuously valid and the FIFO not full, grants cycle 0,1,2,3,0,...
  - Each requester waits at most NUM_REQ-1 push cycles.

Test Plan:
- Reset then idle, no stimulus -> empty = 1, full = 0, count = 0, req_ready = 0000, pop_ack = 0.
- req_valid = 1111 with data 0xA0..0xA3, no pop, for 4 cycles -> grants 0,1,2,3 in order; addresses 0..3 written with A0, A1, A2, A3; count = 4.
- Only req 2 valid for 3 cycles, then req 1 and req 3 valid together -> first contested grant goes to req 3 (search starts after 2), then req 1.
- Push 16 words -> full = 1, req_ready = 0. Then pop and req 0 valid in the same cycle -> pop_ack = 1, no grant, count = 15. Next cycle -> req 0 granted, count = 16.
- Fill and drain 20 words with interleaved push/pop -> pointers wrap 15 -> 0; popped data matches push order exactly.
- From empty, push and pop the same cycle -> pop_ack = 0, count = 1.
- Mid-stream rst pulse at count = 7 -> next cycle count = 0, empty = 1; grant order restarts from req 0.
